// File: rtl/afe7225_cfg_pkg.sv
// Shared constants for the AFE7225 SPI configuration writer: frame width, FSM
// encoding, timing defaults and the power-up register image.
package afe7225_cfg_pkg;

  localparam int FRAME_W       = 16;
  localparam int ADDR_MAX_DEF  = 43;
  localparam int SCLK_HALF_DEF = 8;
  localparam int GAP_CYC_DEF   = 32;

  localparam logic [7:0] CFG_DATA_MUL  = 8'h1D;
  localparam logic [7:0] CFG_DATA_SEED = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_NEXT  = 3'd4
  } state_t;

  // Register image: address = index, data derived from the index so every entry is distinct.
  function automatic logic [FRAME_W-1:0] cfg_word(input logic [7:0] idx);
    logic [7:0] data;
    data = (idx * CFG_DATA_MUL) ^ CFG_DATA_SEED;
    return {idx, data};
  endfunction

endpackage

// File: rtl/afe7225_cfg_rom.sv
// Configuration table lookup with one cycle of read latency; out-of-range indices read as zero.
module afe7225_cfg_rom
  import afe7225_cfg_pkg::*;
#(
  parameter int ADDR_MAX = ADDR_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         index,
  output logic [FRAME_W-1:0] word
);

  localparam logic [7:0] IDX_LAST = 8'(ADDR_MAX - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    word <= '0;
    else if (index <= IDX_LAST) word <= cfg_word(index);
    else                        word <= '0;
  end

endmodule

// File: rtl/afe7225_spi_writer.sv
// SPI writer for the AFE7225: streams the configuration table or a single word as 16-bit frames.
// Optional readback (o_rd_data/o_rd_vld) is built when AFE7225_SPI_READBACK_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for i_config (table) or i_wr_rdy (single word)
//   LOAD  | wait one cycle for the ROM, then drop LE and present bit 15
//   SHIFT | 32 SCLK half-periods plus one trailing half-period before LE rises
//   GAP   | LE high, SCLK/MOSI low for GAP_CYC cycles
//   NEXT  | advance the table index or finish with o_done
module afe7225_spi_writer
  import afe7225_cfg_pkg::*;
#(
  parameter int ADDR_MAX  = ADDR_MAX_DEF,
  parameter int SCLK_HALF = SCLK_HALF_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_config,
  input  logic [15:0] i_wr_data,
  input  logic        i_wr_rdy,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_spi_clk,
  output logic        o_spi_mosi,
  output logic        o_spi_le,
  input  logic        i_spi_miso,
  output logic        o_pd
`ifdef AFE7225_SPI_READBACK_EN
  ,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_vld
`endif
);

  localparam logic [7:0]  DIV_RLD   = 8'(SCLK_HALF - 1);
  localparam logic [15:0] GAP_RLD   = 16'(GAP_CYC - 1);
  localparam logic [7:0]  IDX_LAST  = 8'(ADDR_MAX - 1);
  localparam logic [5:0]  EDGE_LAST = 6'(2 * FRAME_W);
  localparam logic [5:0]  RD_FIRST  = 6'(FRAME_W);

  state_t               state;
  logic [7:0]           index;
  logic                 tbl_mode;
  logic                 ld_wait;
  logic [FRAME_W-1:0]   word_lat;
  logic [FRAME_W-1:0]   shreg;
  logic [FRAME_W-1:0]   rom_q;
  logic [FRAME_W-1:0]   frame_word;
  logic [7:0]           div_cnt;
  logic [5:0]           edge_cnt;
  logic [15:0]          gap_cnt;

  afe7225_cfg_rom #(.ADDR_MAX(ADDR_MAX)) u_cfg_rom (
    .clk   (clk),
    .rst   (rst),
    .index (index),
    .word  (rom_q)
  );

  assign frame_word = tbl_mode ? rom_q : word_lat;
  assign o_pd       = 1'b0;

`ifdef AFE7225_SPI_READBACK_EN
  logic [7:0] rd_sh;
  logic       rd_op;
`else
  logic       unused_miso;
  assign unused_miso = i_spi_miso;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      index      <= '0;
      tbl_mode   <= 1'b0;
      ld_wait    <= 1'b0;
      word_lat   <= '0;
      shreg      <= '0;
      div_cnt    <= '0;
      edge_cnt   <= '0;
      gap_cnt    <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_spi_clk  <= 1'b0;
      o_spi_mosi <= 1'b0;
      o_spi_le   <= 1'b1;
`ifdef AFE7225_SPI_READBACK_EN
      rd_sh      <= '0;
      rd_op      <= 1'b0;
      o_rd_data  <= '0;
      o_rd_vld   <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
`ifdef AFE7225_SPI_READBACK_EN
      o_rd_vld <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          ld_wait <= 1'b0;
          if (i_config) begin
            tbl_mode <= 1'b1;
            index    <= '0;
            o_busy   <= 1'b1;
            state    <= ST_LOAD;
          end else if (i_wr_rdy) begin
            tbl_mode <= 1'b0;
            word_lat <= i_wr_data;
            o_busy   <= 1'b1;
            state    <= ST_LOAD;
          end
        end

        // First LOAD cycle only lets the ROM register the current index.
        ST_LOAD: begin
          if (!ld_wait) begin
            ld_wait <= 1'b1;
          end else begin
            ld_wait    <= 1'b0;
            shreg      <= frame_word;
            o_spi_le   <= 1'b0;
            o_spi_mosi <= frame_word[FRAME_W-1];
            div_cnt    <= DIV_RLD;
            edge_cnt   <= '0;
            state      <= ST_SHIFT;
`ifdef AFE7225_SPI_READBACK_EN
            rd_op      <= !tbl_mode && word_lat[FRAME_W-1];
`endif
          end
        end

        ST_SHIFT: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt <= DIV_RLD;
            if (edge_cnt == EDGE_LAST) begin
              o_spi_le <= 1'b1;
              gap_cnt  <= GAP_RLD;
              state    <= ST_GAP;
            end else begin
              edge_cnt  <= edge_cnt + 6'd1;
              o_spi_clk <= ~o_spi_clk;
              // Falling edge: next bit out; zeros trail in so MOSI ends low.
              if (o_spi_clk) begin
                shreg      <= {shreg[FRAME_W-2:0], 1'b0};
                o_spi_mosi <= shreg[FRAME_W-2];
              end
`ifdef AFE7225_SPI_READBACK_EN
              else if (edge_cnt >= RD_FIRST) begin
                rd_sh <= {rd_sh[6:0], i_spi_miso};
              end
`endif
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == 16'd0) state <= ST_NEXT;
          else                  gap_cnt <= gap_cnt - 16'd1;
        end

        ST_NEXT: begin
          if (tbl_mode && (index < IDX_LAST)) begin
            index <= index + 8'd1;
            state <= ST_LOAD;
          end else begin
            state  <= ST_IDLE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
`ifdef AFE7225_SPI_READBACK_EN
            o_rd_vld  <= rd_op;
            o_rd_data <= rd_sh;
`endif
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afe7225_spi_writer.sv
// Bench for afe7225_spi_writer: vector table, hand-written corner sequences and random single writes,
// checked by a passive SPI monitor against an expected-frame list.
module tb_afe7225_spi_writer;
  import afe7225_cfg_pkg::*;

  localparam int SCLK_HALF = SCLK_HALF_DEF;
  localparam int GAP_CYC   = GAP_CYC_DEF;
  localparam int ADDR_MAX  = ADDR_MAX_DEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_config = 1'b0;
  logic [15:0] i_wr_data = 16'h0;
  logic        i_wr_rdy = 1'b0;
  logic        o_busy, o_done, o_spi_clk, o_spi_mosi, o_spi_le, o_pd;
  logic        i_spi_miso = 1'b0;
`ifdef AFE7225_SPI_READBACK_EN
  logic [7:0]  o_rd_data;
  logic        o_rd_vld;
`endif

  afe7225_spi_writer dut (
    .clk        (clk),
    .rst        (rst),
    .i_config   (i_config),
    .i_wr_data  (i_wr_data),
    .i_wr_rdy   (i_wr_rdy),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_spi_clk  (o_spi_clk),
    .o_spi_mosi (o_spi_mosi),
    .o_spi_le   (o_spi_le),
    .i_spi_miso (i_spi_miso),
    .o_pd       (o_pd)
`ifdef AFE7225_SPI_READBACK_EN
    ,
    .o_rd_data  (o_rd_data),
    .o_rd_vld   (o_rd_vld)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- passive SPI monitor / MISO model ----------------
  logic [15:0] frames[$];
  int          nbits_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] cur;
  int nbits, nfall, cyc, le_fall_cyc, le_rise_cyc, last_edge_cyc;
  int le_fall_cnt, done_cnt, proto_err, rd_vld_cnt;
  logic [7:0] rd_cap;
  logic [7:0] miso_byte = 8'h5A;
  logic mon_en = 1'b0, le_rise_valid = 1'b0;
  logic prev_le = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (prev_le && !o_spi_le) begin
      le_fall_cnt++;
      if (mon_en && le_rise_valid && (cyc - le_rise_cyc) < GAP_CYC) proto_err++;
      le_fall_cyc = cyc; cur = '0; nbits = 0; nfall = 0;
    end
    if (!prev_sclk && o_spi_clk) begin
      if (mon_en && o_spi_le) proto_err++;
      if (mon_en && nbits == 0 && (cyc - le_fall_cyc) != SCLK_HALF) proto_err++;
      if (mon_en && nbits != 0 && (cyc - last_edge_cyc) != SCLK_HALF) proto_err++;
      cur = {cur[14:0], o_spi_mosi}; nbits++; last_edge_cyc = cyc;
    end
    if (prev_sclk && !o_spi_clk) begin
      if (mon_en && (cyc - last_edge_cyc) != SCLK_HALF) proto_err++;
      nfall++; last_edge_cyc = cyc;
    end
    if (!prev_le && o_spi_le) begin
      frames.push_back(cur); nbits_q.push_back(nbits);
      if (mon_en && (cyc - last_edge_cyc) != SCLK_HALF) proto_err++;
      le_rise_cyc = cyc; le_rise_valid = 1'b1;
    end
    // MOSI may only move when LE falls or SCLK falls.
    if (mon_en && o_spi_mosi !== prev_mosi && !(prev_sclk && !o_spi_clk) && !(prev_le && !o_spi_le))
      proto_err++;
    if (mon_en && o_spi_le && (o_spi_clk || o_spi_mosi)) proto_err++;
    if (mon_en && o_pd) proto_err++;
    if (o_done) begin
      done_cnt++;
      if (mon_en && o_busy) proto_err++;
    end
`ifdef AFE7225_SPI_READBACK_EN
    if (o_rd_vld) begin
      rd_vld_cnt++; rd_cap = o_rd_data;
      if (mon_en && !o_done) proto_err++;
    end
`endif
    i_spi_miso = (nfall >= 8 && nfall <= 15) ? miso_byte[15 - nfall] : 1'b0;
    prev_le = o_spi_le; prev_sclk = o_spi_clk; prev_mosi = o_spi_mosi;
  end

  // ---------------- helpers ----------------
  task automatic clear_mon();
    frames.delete(); nbits_q.delete(); exp_q.delete();
    done_cnt = 0; proto_err = 0; rd_vld_cnt = 0; le_rise_valid = 1'b0;
  endtask

  // Reference model: the list of words the device should see.
  task automatic model(input logic cfg, input logic wr, input logic [15:0] data);
    exp_q.delete();
    if (cfg) for (int i = 0; i < ADDR_MAX; i++) exp_q.push_back(cfg_word(8'(i)));
    else if (wr) exp_q.push_back(data);
  endtask

  task automatic pulse(input logic cfg, input logic wr, input logic [15:0] data, input string tag);
    @(posedge clk); #1;
    i_config = cfg; i_wr_rdy = wr; i_wr_data = data;
    @(posedge clk); #1;
    i_config = 1'b0; i_wr_rdy = 1'b0; i_wr_data = 16'($urandom);
    check({tag, "_busy_next_cycle"}, {31'd0, o_busy}, {31'd0, cfg | wr});
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && done_cnt == 0; c++) @(posedge clk);
    repeat (GAP_CYC + 20) @(posedge clk);
    #1;
  endtask

  task automatic compare_frames(input string tag);
    int bad = 0;
    int badn = 0;
    check({tag, "_nframes"}, frames.size(), exp_q.size());
    for (int i = 0; i < frames.size() && i < exp_q.size(); i++)
      if (frames[i] !== exp_q[i]) bad++;
    foreach (nbits_q[i]) if (nbits_q[i] != 16) badn++;
    check({tag, "_word_mismatches"}, bad, 0);
    check({tag, "_bad_bitcounts"}, badn, 0);
    check({tag, "_protocol_errs"}, proto_err, 0);
  endtask

  typedef struct {
    logic        cfg;
    logic        wr;
    logic [15:0] data;
    int          n_frames;
    logic [15:0] first;
    int          n_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h0A5C, 1,  16'h0A5C,   1};
    vecs[1] = '{1'b0, 1'b1, 16'hFFFF, 1,  16'hFFFF,   1};
    vecs[2] = '{1'b0, 1'b1, 16'h0001, 1,  16'h0001,   1};
    vecs[3] = '{1'b0, 1'b1, 16'h8000, 1,  16'h8000,   1};
    vecs[4] = '{1'b0, 1'b0, 16'h1234, 0,  16'h0000,   0};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 43, cfg_word(0), 1};
    vecs[6] = '{1'b1, 1'b1, 16'h1234, 43, cfg_word(0), 1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, o_busy}, 0);
    check("rst_done", {31'd0, o_done}, 0);
    check("rst_sclk", {31'd0, o_spi_clk}, 0);
    check("rst_mosi", {31'd0, o_spi_mosi}, 0);
    check("rst_le", {31'd0, o_spi_le}, 1);
    check("rst_pd", {31'd0, o_pd}, 0);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    mon_en = 1'b1;

    for (int v = 0; v < 7; v++) begin
      int hits = 0;
      string tag;
      tag = $sformatf("vec%0d", v);
      clear_mon();
      pulse(vecs[v].cfg, vecs[v].wr, vecs[v].data, tag);
      wait_done(vecs[v].n_frames * 400 + 200);
      model(vecs[v].cfg, vecs[v].wr, vecs[v].data);
      check({tag, "_nframes_vec"}, frames.size(), vecs[v].n_frames);
      if (frames.size() > 0) check({tag, "_first_word"}, {16'd0, frames[0]}, {16'd0, vecs[v].first});
      compare_frames(tag);
      check({tag, "_done_count"}, done_cnt, vecs[v].n_done);
      check({tag, "_busy_after"}, {31'd0, o_busy}, 0);
      if (vecs[v].cfg && vecs[v].wr) begin
        foreach (frames[i]) if (frames[i] == vecs[v].data) hits++;
        check({tag, "_single_word_dropped"}, hits, 0);
      end
    end

    // i_config re-pulsed during frame 10, plus a stray single write: both ignored.
    begin
      int hits = 0;
      clear_mon();
      pulse(1'b1, 1'b0, 16'h0, "repulse");
      for (int c = 0; c < 5000 && frames.size() < 10; c++) @(posedge clk);
      check("repulse_reached_frame10", frames.size(), 10);
      #1 i_config = 1'b1;
      @(posedge clk); #1 i_config = 1'b0; i_wr_rdy = 1'b1; i_wr_data = 16'h1234;
      @(posedge clk); #1 i_wr_rdy = 1'b0;
      wait_done(43 * 400);
      model(1'b1, 1'b0, 16'h0);
      compare_frames("repulse");
      check("repulse_done_count", done_cnt, 1);
      foreach (frames[i]) if (frames[i] == 16'h1234) hits++;
      check("repulse_stray_word", hits, 0);
    end

    // Asynchronous reset in the middle of frame 5.
    begin
      int falls;
      clear_mon();
      pulse(1'b1, 1'b0, 16'h0, "midrst");
      for (int c = 0; c < 3000 && !(frames.size() == 4 && !o_spi_le && nbits >= 3); c++) @(posedge clk);
      check("midrst_in_frame5", frames.size(), 4);
      @(negedge clk); #2;
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_le", {31'd0, o_spi_le}, 1);
      check("midrst_sclk", {31'd0, o_spi_clk}, 0);
      check("midrst_busy", {31'd0, o_busy}, 0);
      check("midrst_mosi", {31'd0, o_spi_mosi}, 0);
      @(posedge clk); @(posedge clk); #2 rst = 1'b0;
      falls = le_fall_cnt;
      repeat (1000) @(posedge clk);
      #1;
      check("midrst_no_resume", le_fall_cnt - falls, 0);
      check("midrst_idle_busy", {31'd0, o_busy}, 0);
      clear_mon();
      mon_en = 1'b1;
    end

    // Random single writes with ignored requests injected while busy.
    for (int it = 0; it < 12; it++) begin
      logic [15:0] data;
      string tag;
      tag = $sformatf("rand%0d", it);
      data = 16'($urandom);
      clear_mon();
      pulse(1'b0, 1'b1, data, tag);
      repeat ($urandom_range(10, 250)) @(posedge clk);
      #1 i_wr_rdy = 1'b1; i_wr_data = ~data; i_config = 1'($urandom_range(0, 1));
      @(posedge clk); #1 i_wr_rdy = 1'b0; i_config = 1'b0;
      wait_done(600);
      model(1'b0, 1'b1, data);
      compare_frames(tag);
      check({tag, "_done_count"}, done_cnt, 1);
    end

`ifdef AFE7225_SPI_READBACK_EN
    miso_byte = 8'hC3;
    clear_mon();
    pulse(1'b0, 1'b1, 16'h8300, "rd");
    wait_done(600);
    model(1'b0, 1'b1, 16'h8300);
    compare_frames("rd");
    check("rd_vld_count", rd_vld_cnt, 1);
    check("rd_data", {24'd0, rd_cap}, 32'hC3);
    clear_mon();
    pulse(1'b0, 1'b1, 16'h0300, "wr_no_rd");
    wait_done(600);
    check("wr_no_rd_vld", rd_vld_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/afe7225_spi_writer.md
AFE7225_SPI_WRITER -- requirements
Module: afe7225_spi_writer

Interface
REQ-001 SHALL have parameter ADDR_MAX, default 43, meaning the number of configuration-table entries sent per config sequence.
REQ-002 SHALL have parameter SCLK_HALF, default 8, meaning the SPI clock half-period in clk cycles; legal range is 2..255.
REQ-003 SHALL have parameter GAP_CYC, default 32, meaning the minimum number of clk cycles o_spi_le stays high between frames.
REQ-004 clk  in  1  system clock, 100 MHz.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 i_config  in  1  one-cycle pulse that starts a full-table sequence.
REQ-007 i_wr_data  in  16  single-frame word: [15:8] address, [7:0] data.
REQ-008 i_wr_rdy  in  1  one-cycle strobe that requests a single-frame write of i_wr_data.
REQ-009 o_busy  out  1  high while a sequence or single frame is in progress.
REQ-010 o_done  out  1  one-cycle pulse when a sequence or single frame completes.
REQ-011 o_spi_clk, o_spi_mosi, o_spi_le  out  1 each  SPI clock, serial data, and active-low enable.
REQ-012 i_spi_miso  in  1  SPI serial data from the device.
REQ-013 o_pd  out  1  AFE power-down; held 0.

Function
REQ-014 SHALL implement the states IDLE, LOAD, SHIFT, GAP and NEXT.
REQ-015 IDLE SHALL transition to LOAD on i_config (index=0, table mode) or on i_wr_rdy (single mode, i_wr_data latched); o_busy SHALL assert on the following cycle.
REQ-016 i_config and i_wr_rdy asserted in the same cycle: i_config SHALL win and the single write SHALL be dropped.
REQ-017 i_config or i_wr_rdy received while o_busy is high SHALL be ignored, with no queuing.
REQ-018 LOAD SHALL fetch the 16-bit word (from the table at the current index, or the latched word), drive o_spi_le low and o_spi_mosi to bit 15, then enter SHIFT.
REQ-019 SHIFT: o_spi_clk SHALL idle low, rise SCLK_HALF cycles after o_spi_le falls, and toggle every SCLK_HALF cycles; o_spi_mosi SHALL change only on o_spi_clk falling edges, MSB first.
REQ-020 A frame SHALL be exactly 16 SCLK periods; o_spi_le SHALL rise SCLK_HALF cycles after the 16th falling edge; the state machine SHALL then enter GAP.
REQ-021 GAP SHALL hold o_spi_le high, o_spi_clk low and o_spi_mosi low for GAP_CYC cycles, then enter NEXT.
REQ-022 NEXT in table mode: if index < ADDR_MAX-1, index SHALL be incremented and the state machine SHALL return to LOAD; otherwise it SHALL go to IDLE with o_done pulsed.
REQ-023 NEXT in single mode SHALL go to IDLE with o_done pulsed; o_busy SHALL drop in the same cycle as o_done.
REQ-024 The index counter SHALL be 8 bits; the table SHALL never be read past ADDR_MAX-1, and the index SHALL not wrap.
REQ-025 The SCLK divider counter SHALL be 8 bits and SHALL reload at SCLK_HALF-1.

Reset
REQ-026 rst SHALL force state=IDLE, index=0, o_busy=0, o_done=0, o_spi_clk=0, o_spi_mosi=0, o_spi_le=1, o_pd=0.
REQ-027 rst asserted mid-frame SHALL abort the frame immediately, driving the outputs to the REQ-026 values asynchronously; no partial frame SHALL resume after release.

Configuration
REQ-028 Macro AFE7225_SPI_READBACK_EN defined SHALL add outputs o_rd_data[7:0] and o_rd_vld, and treat a single-mode word with bit 15 = 1 as a read.
REQ-029 With AFE7225_SPI_READBACK_EN defined, i_spi_miso SHALL be sampled on o_spi_clk rising edges for bits 7..0; o_rd_vld SHALL pulse one cycle together with o_done, carrying o_rd_data.
REQ-030 Without AFE7225_SPI_READBACK_EN, the read ports and the sampling logic SHALL be absent, and bit 15 SHALL be transmitted verbatim.

Structure
REQ-031 Package afe7225_cfg_pkg SHALL hold the 16-bit frame width, the state encoding, the SCLK_HALF and GAP_CYC defaults, and the configuration-table constants.
REQ-032 Sub-module afe7225_cfg_rom SHALL provide a registered, one-cycle-latency lookup from index to 16-bit word; LOAD SHALL account for this latency.

Verification
REQ-033 i_config pulse, SCLK_HALF=8 -> 43 frames, each 16 rising edges with o_spi_le low; o_done once; o_busy low afterwards.
REQ-034 i_wr_rdy with i_wr_data=16'h0A5C -> MOSI bit sequence 0000_1010_0101_1100, sampled on rising edges; o_done after a single frame.
REQ-035 i_config and i_wr_rdy in the same cycle -> table sequence runs and the single word 16'h1234 never appears on MOSI.
REQ-036 i_config re-pulsed at frame 10 -> ignored; the total frame count stays 43.
REQ-037 rst asserted mid-SHIFT of frame 5 -> o_spi_le=1 and o_spi_clk=0 within the reset assertion; after release, no activity until a new i_config.
REQ-038 AFE7225_SPI_READBACK_EN, i_wr_data=16'h8300, MISO model returning 8'hC3 -> o_rd_vld=1 with o_rd_data=8'hC3.
